sparse_weight_packer: RTL and testbench
=======================================

SPARSE_WEIGHT_PACKER -- requirements
Module: sparse_weight_packer

Interface
REQ-001 SHALL have parameter bw, default 4: bit width of one signed weight.
REQ-002 SHALL have parameter nnz, default 2: kept (non-zero) weights per group; 1 <= nnz <= n.
REQ-003 SHALL have parameter n, default 4: dense weights per group.
REQ-004 SHALL have parameter M, default 4: groups per packed row (one per dot-product lane).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-007 SHALL have port in_valid  input  1  dense group present.
REQ-008 SHALL have port in_ready  output  1  packer accepts a group this cycle.
REQ-009 SHALL have port in_dense  input  n*bw  dense group; element k at [(k+1)*bw-1 : k*bw].
REQ-010 SHALL have port flush  input  1  pad and close a partial row.
REQ-011 SHALL have port out_valid  output  1  packed row available.
REQ-012 SHALL have port out_ready  input  1  consumer takes the row.
REQ-013 SHALL have port weights_flat  output  M*nnz*bw  compressed weights; lane i at [(i+1)*nnz*bw-1 : i*nnz*bw].
REQ-014 SHALL have port w_index  output  M*n  kept-position masks; lane i at [(i+1)*n-1 : i*n].
REQ-015 SHALL have port err_overflow  output  1  sticky: some group had more than nnz non-zeros.

Function
REQ-016 States SHALL be COLLECT and FULL; in_ready = 1 exactly in COLLECT; out_valid = 1 exactly in FULL.
REQ-017 Accept = in_valid & in_ready; each accept SHALL encode in_dense into lane group_cnt (0..M-1), then increment group_cnt.
REQ-018 Encoding: kept set = non-zero elements; if fewer than nnz, pad with lowest-index zero elements; mask always has exactly nnz bits set.
REQ-019 Kept elements SHALL occupy slots 0..nnz-1 in ascending element index; slot j at lane bits [j*bw +: bw].
REQ-020 If more than nnz non-zeros, default SHALL keep the nnz lowest-index non-zeros and set err_overflow the cycle after the accept.
REQ-021 M-th accept SHALL move COLLECT->FULL; out_valid SHALL rise the cycle after that accept.
REQ-022 In FULL, out_valid & out_ready SHALL return to COLLECT with group_cnt = 0; in_ready SHALL rise the next cycle.
REQ-023 weights_flat and w_index SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-024 flush in COLLECT with group_cnt > 0 SHALL fill remaining lanes with zero weights, mask with lowest nnz bits set, and enter FULL next cycle.
REQ-025 flush in the same cycle as an accept SHALL include that group first; if it is the M-th group, flush has no extra effect.
REQ-026 flush SHALL be ignored in FULL or when group_cnt = 0.
REQ-027 Arithmetic: magnitude of an element SHALL be its absolute value extended to bw+1 bits (-2^(bw-1) is largest).

Reset
REQ-028 reset = 0 SHALL immediately force state COLLECT, group_cnt 0, out_valid 0, in_ready 1, weights_flat 0, w_index 0, err_overflow 0.
REQ-029 reset asserted mid-row SHALL discard all partially collected groups; no row is emitted.
REQ-030 err_overflow SHALL clear only on reset.

Configuration
REQ-031 Macro SPW_MAG_PRUNE_EN defined: overflowing groups SHALL keep the nnz largest-magnitude non-zeros, ties to lower index, still emitted in ascending index order; err_overflow behaviour unchanged.
REQ-032 Macro SPW_MAG_PRUNE_EN undefined: REQ-020 lowest-index selection SHALL apply and no magnitude logic SHALL be present.

Verification (defaults; groups listed e0,e1,e2,e3)
REQ-033 Four accepts of (-2,0,3,0) -> out_valid 1 cycle after 4th accept; each lane slots (-2,3); w_index = 16'h5555; err_overflow 0.
REQ-034 Group (0,0,0,5) -> lane slots (0,5), mask 4'b1001; group (0,0,0,0) -> slots (0,0), mask 4'b0011.
REQ-035 Group (1,-7,2,3) -> default slots (1,-7), mask 4'b0011, err_overflow 1; with SPW_MAG_PRUNE_EN slots (-7,3), mask 4'b1010.
REQ-036 Full row with out_ready held 0 for 5 cycles -> in_ready 0, outputs unchanged throughout; out_ready 1 -> in_ready 1 next cycle.
REQ-037 Two accepts then flush -> lanes 2,3 mask 4'b0011 with zero weights, out_valid next cycle; flush with group_cnt = 0 -> no change.
REQ-038 reset pulsed after 3 accepts -> all outputs at reset values, no out_valid; next 4 accepts produce a normal row.

Source files
------------

// File: rtl/sparse_weight_packer.sv
`default_nettype none
// ============================================================================
// Module   : sparse_weight_packer
// Brief    : Collects M dense weight groups of n signed bw-bit elements and
//            compresses each to nnz kept weights plus an n-bit kept-position
//            mask, emitting one packed row per M groups (or on flush).
//            Optional macro SPW_MAG_PRUNE_EN: overflowing groups keep the
//            nnz largest-magnitude non-zeros instead of the lowest-index ones.
// Revision : 1.0 - initial release
// ============================================================================
module sparse_weight_packer #(
    parameter int bw  = 4,
    parameter int nnz = 2,
    parameter int n   = 4,
    parameter int M   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [n*bw-1:0]       in_dense,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [M*nnz*bw-1:0]   weights_flat,
    output logic [M*n-1:0]        w_index,
    output logic                  err_overflow
);

    localparam int            c_cnt_w    = (M > 1) ? $clog2(M) : 1;
    localparam logic [n-1:0]  c_pad_mask = n'((64'd1 << nnz) - 64'd1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [c_cnt_w-1:0]     r_group_cnt;
    logic [M*nnz*bw-1:0]    r_weights;
    logic [M*n-1:0]         r_index;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_last;
    logic                   w_flush_go;
    logic                   w_row_done;
    logic [n-1:0]           w_nz;
    logic [n-1:0]           w_mask;
    logic [nnz*bw-1:0]      w_packed;
    logic                   w_overflow;

    // Accept is decoded from the state register directly to keep in_ready
    // out of the next-state loop.
    assign w_accept   = in_valid & (r_state == COLLECT);
    assign w_last     = (r_group_cnt == c_cnt_w'(M - 1));
    // A flush coinciding with an accept counts that group first, so the row
    // is non-empty whenever either a group is already held or one arrives now.
    assign w_flush_go = flush & (r_state == COLLECT) & ((r_group_cnt != '0) | w_accept);
    assign w_row_done = (w_accept & w_last) | w_flush_go;

    assign weights_flat = r_weights;
    assign w_index      = r_index;
    assign err_overflow = r_err;

`ifdef SPW_MAG_PRUNE_EN
    logic [n-1:0][bw:0]     w_mag;

    // Absolute value in bw+1 bits so the most negative code has the largest magnitude.
    always_comb begin
        for (int k = 0; k < n; k++) begin
            w_mag[k] = in_dense[k*bw+bw-1] ? (~{in_dense[k*bw+bw-1], in_dense[k*bw +: bw]} + 1'b1)
                                           : {1'b0, in_dense[k*bw +: bw]};
        end
    end
`endif

    // Choose the kept positions for the incoming group and pack them by ascending index.
    always_comb begin : p_encode
        int nz_cnt;
        int kept;
        int slot;
`ifdef SPW_MAG_PRUNE_EN
        int rank;
`endif
        w_nz       = '0;
        w_mask     = '0;
        w_packed   = '0;
        nz_cnt     = 0;
        kept       = 0;
        slot       = 0;
        for (int k = 0; k < n; k++) begin
            w_nz[k] = |in_dense[k*bw +: bw];
            if (w_nz[k]) nz_cnt++;
        end
        w_overflow = (nz_cnt > nnz);
`ifdef SPW_MAG_PRUNE_EN
        // A non-zero is kept when fewer than nnz non-zeros beat it
        // (larger magnitude, or equal magnitude at a lower index).
        for (int k = 0; k < n; k++) begin
            rank = 0;
            for (int i = 0; i < n; i++) begin
                if (w_nz[i] && (i != k) &&
                    ((w_mag[i] > w_mag[k]) || ((w_mag[i] == w_mag[k]) && (i < k)))) begin
                    rank++;
                end
            end
            if (w_nz[k] && (rank < nnz)) begin
                w_mask[k] = 1'b1;
                kept++;
            end
        end
`else
        for (int k = 0; k < n; k++) begin
            if (w_nz[k] && (kept < nnz)) begin
                w_mask[k] = 1'b1;
                kept++;
            end
        end
`endif
        // Top up with the lowest-index zeros so the mask always has nnz bits.
        for (int k = 0; k < n; k++) begin
            if (!w_nz[k] && (kept < nnz)) begin
                w_mask[k] = 1'b1;
                kept++;
            end
        end
        for (int k = 0; k < n; k++) begin
            if (w_mask[k] && (slot < nnz)) begin
                w_packed[slot*bw +: bw] = in_dense[k*bw +: bw];
                slot++;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= COLLECT;
        else        r_state <= w_next_state;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            COLLECT: begin
                in_ready = 1'b1;
                if (w_row_done) w_next_state = FULL;
            end
            FULL: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = COLLECT;
            end
            default: w_next_state = COLLECT;
        endcase
    end

    // Lane storage, group counter and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_group_cnt <= '0;
            r_weights   <= '0;
            r_index     <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept && w_overflow) r_err <= 1'b1;
            if (w_row_done)    r_group_cnt <= '0;
            else if (w_accept) r_group_cnt <= r_group_cnt + 1'b1;
            for (int i = 0; i < M; i++) begin
                if (w_accept && (r_group_cnt == c_cnt_w'(i))) begin
                    r_weights[i*nnz*bw +: nnz*bw] <= w_packed;
                    r_index[i*n +: n]             <= w_mask;
                end else if (w_flush_go && (i >= int'(r_group_cnt))) begin
                    r_weights[i*nnz*bw +: nnz*bw] <= '0;
                    r_index[i*n +: n]             <= c_pad_mask;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sparse_weight_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sparse_weight_packer
// Brief    : Directed, table-driven bench for sparse_weight_packer at the
//            default parameters (bw=4, nnz=2, n=4, M=4). Expected values for
//            overflowing groups follow SPW_MAG_PRUNE_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sparse_weight_packer;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [15:0] in_dense  = '0;
    logic        flush     = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] weights_flat;
    logic [15:0] w_index;
    logic        err_overflow;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] dense;
        logic [7:0]  slots;
        logic [3:0]  mask;
        logic        err;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    sparse_weight_packer #(.bw(4), .nnz(2), .n(4), .M(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dense     (in_dense),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .weights_flat (weights_flat),
        .w_index      (w_index),
        .err_overflow (err_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_in_ready"},  32'(in_ready),  32'h1);
        check({tag, "_weights"},   weights_flat,   32'h0);
        check({tag, "_index"},     32'(w_index),   32'h0);
        check({tag, "_err"},       32'(err_overflow), 32'h0);
    endtask

    // Reset asserted and released away from the active edge.
    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    // Offer one group, waiting a bounded number of cycles for in_ready.
    task automatic accept(input logic [15:0] d, input logic fl);
        int w = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        check("accept_in_ready", 32'(in_ready), 32'h1);
        in_valid = 1'b1;
        in_dense = d;
        flush    = fl;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h030E, 8'h3E, 4'b0101, 1'b0};
        vecs[1] = '{16'h5000, 8'h50, 4'b1001, 1'b0};
        vecs[2] = '{16'h0000, 8'h00, 4'b0011, 1'b0};
        vecs[3] = '{16'h0078, 8'h78, 4'b0011, 1'b0};
        vecs[4] = '{16'hF040, 8'hF4, 4'b1010, 1'b0};
        vecs[5] = '{16'h0600, 8'h60, 4'b0101, 1'b0};
`ifdef SPW_MAG_PRUNE_EN
        vecs[6] = '{16'h3291, 8'h39, 4'b1010, 1'b1};
        vecs[7] = '{16'h7118, 8'h78, 4'b1001, 1'b1};
`else
        vecs[6] = '{16'h3291, 8'h91, 4'b0011, 1'b1};
        vecs[7] = '{16'h7118, 8'h18, 4'b0011, 1'b1};
`endif
        vecs[8] = '{16'h12E2, 8'hE2, 4'b0011, 1'b1};

        // Power-on reset state.
        #2;
        check_reset("por");
        step();
        reset = 1'b1;

        // Uniform rows: four identical groups, row appears right after the 4th accept.
        for (int v = 0; v < 9; v++) begin
            do_reset();
            for (int g = 0; g < 4; g++) accept(vecs[v].dense, 1'b0);
            check($sformatf("vec%0d_out_valid", v), 32'(out_valid), 32'h1);
            check($sformatf("vec%0d_weights", v), weights_flat, {4{vecs[v].slots}});
            check($sformatf("vec%0d_index", v), 32'(w_index), 32'({4{vecs[v].mask}}));
            check($sformatf("vec%0d_err", v), 32'(err_overflow), 32'(vecs[v].err));
            drain();
            check($sformatf("vec%0d_ready_after", v), 32'(in_ready), 32'h1);
        end

        // Backpressure: row held stable, new groups refused.
        do_reset();
        for (int g = 0; g < 4; g++) accept(16'h030E, 1'b0);
        in_valid = 1'b1;
        in_dense = 16'h5000;
        for (int c = 0; c < 5; c++) begin
            check("hold_out_valid", 32'(out_valid), 32'h1);
            check("hold_in_ready",  32'(in_ready),  32'h0);
            check("hold_weights",   weights_flat,   32'h3E3E3E3E);
            check("hold_index",     32'(w_index),   32'h5555);
            step();
        end
        in_valid = 1'b0;
        drain();
        check("hold_release_in_ready",  32'(in_ready),  32'h1);
        check("hold_release_out_valid", 32'(out_valid), 32'h0);

        // Flush with nothing collected is ignored.
        do_reset();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_empty_out_valid", 32'(out_valid), 32'h0);
        check("flush_empty_in_ready",  32'(in_ready),  32'h1);

        // Two groups then flush: lanes 2,3 padded.
        accept(16'h030E, 1'b0);
        accept(16'h030E, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush2_out_valid", 32'(out_valid), 32'h1);
        check("flush2_weights",   weights_flat,   32'h00003E3E);
        check("flush2_index",     32'(w_index),   32'h3355);
        drain();

        // Flush together with the second accept includes that group.
        do_reset();
        accept(16'h030E, 1'b0);
        accept(16'h030E, 1'b1);
        check("flushacc_out_valid", 32'(out_valid), 32'h1);
        check("flushacc_weights",   weights_flat,   32'h00003E3E);
        check("flushacc_index",     32'(w_index),   32'h3355);
        drain();

        // Reset mid-row discards collected groups.
        do_reset();
        for (int g = 0; g < 3; g++) accept(16'h5000, 1'b0);
        reset = 1'b0;
        #1;
        check_reset("midrow");
        step();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("midrow_no_row", 32'(out_valid), 32'h0);
            step();
        end
        for (int g = 0; g < 4; g++) accept(16'h030E, 1'b0);
        check("midrow_row_valid", 32'(out_valid), 32'h1);
        check("midrow_weights",   weights_flat,   32'h3E3E3E3E);
        check("midrow_index",     32'(w_index),   32'h5555);
        drain();

        // Mixed lanes, then overflow flag timing and stickiness.
        do_reset();
        accept(16'h5000, 1'b0);
        accept(16'h030E, 1'b0);
        accept(16'h0000, 1'b0);
        accept(16'hF040, 1'b0);
        check("mixed_weights", weights_flat,           32'hF4003E50);
        check("mixed_index",   32'(w_index),           32'hA359);
        check("mixed_err",     32'(err_overflow),      32'h0);
        drain();
        accept(16'h3291, 1'b0);
        check("ovf_err_next_cycle", 32'(err_overflow), 32'h1);
        for (int g = 0; g < 3; g++) accept(16'h030E, 1'b0);
        drain();
        for (int g = 0; g < 4; g++) accept(16'h030E, 1'b0);
        check("ovf_err_sticky", 32'(err_overflow), 32'h1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
